fifo_packet_reader: RTL and testbench

- Transactional consumer on the pop side of the transactional FIFO. It drains one packet of a requested length, streams it byte-wise to the packet serializer, then waits for the handshake outcome.
- On ACK it commits the read transaction. On NAK or timeout it rolls back and retransmits from the same FIFO data, up to a retry limit.
- Sits between the endpoint TX FIFO and the USB transmit path.

---
 rtl/fifo_packet_reader.sv | 200 ++++++++++++++++++++
 tb/tb_fifo_packet_reader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packet_reader.sv
// Pop-side consumer of the transactional TX FIFO: streams one packet byte-wise to the
// serializer, then commits or rolls back the FIFO read according to the host handshake.
module fifo_packet_reader #(
   parameter  int DATA_WID       = 8,
   parameter  int LEN_WID        = 10,
   parameter  int TIMEOUT_CYCLES = 1024,
   parameter  int MAX_RETRIES    = 3,
   localparam int RC_WID         = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN_WID-1:0]  pktLen,
   output logic                busy,
   input  logic                dataAvailable,
   input  logic [DATA_WID-1:0] fifoData,
   output logic                popData,
   output logic                popTransDone,
   output logic                popTransSuccess,
   output logic                txValid,
   output logic [DATA_WID-1:0] txData,
   output logic                txLast,
   input  logic                txReady,
   input  logic                ackReceived,
   input  logic                nakReceived,
   input  logic                abort,
   output logic                done,
   output logic                success,
   output logic [RC_WID-1:0]   retryCount
);

   localparam int TO_WID = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      WAIT_ACK,
      COMMIT,
      ROLLBACK,
      FINISH
   } state_t;

   state_t              r_state;
   logic [LEN_WID-1:0]  r_len;
   logic [LEN_WID-1:0]  r_popped;
   logic [TO_WID-1:0]   r_timeout;
   logic [RC_WID-1:0]   r_retry;
   logic                r_aborted;
   logic                r_busy;
   logic                r_txValid;
   logic [DATA_WID-1:0] r_txData;
   logic                r_txLast;
   logic                r_popTransDone;
   logic                r_popTransSuccess;
   logic                r_done;
   logic                r_success;

   logic w_pop;
   logic w_lastAccepted;
   logic w_timeoutHit;
   logic w_retriesExhausted;

   // A pop refills the output register, so it may only happen while that register is
   // empty or being drained this cycle; abort blocks the pop on its own edge.
   assign w_pop = rst_n && (r_state == STREAM) && !abort && dataAvailable &&
                  (r_popped < r_len) && (!r_txValid || txReady);

   assign w_lastAccepted     = r_txValid && txReady && r_txLast;
   assign w_timeoutHit       = (r_timeout == TO_WID'(TIMEOUT_CYCLES - 1));
   assign w_retriesExhausted = (r_retry == RC_WID'(MAX_RETRIES));

   assign busy            = r_busy;
   assign popData         = w_pop;
   assign popTransDone    = r_popTransDone;
   assign popTransSuccess = r_popTransSuccess;
   assign txValid         = r_txValid;
   assign txData          = r_txData;
   assign txLast          = r_txLast;
   assign done            = r_done;
   assign success         = r_success;
   assign retryCount      = r_retry;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_state           <= IDLE;
         r_len             <= '0;
         r_popped          <= '0;
         r_timeout         <= '0;
         r_retry           <= '0;
         r_aborted         <= 1'b0;
         r_busy            <= 1'b0;
         r_txValid         <= 1'b0;
         r_txData          <= '0;
         r_txLast          <= 1'b0;
         r_popTransDone    <= 1'b0;
         r_popTransSuccess <= 1'b0;
         r_done            <= 1'b0;
         r_success         <= 1'b0;
      end else begin
         r_popTransDone    <= 1'b0;
         r_popTransSuccess <= 1'b0;
         r_done            <= 1'b0;

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len     <= pktLen;
                  r_popped  <= '0;
                  r_retry   <= '0;
                  r_timeout <= '0;
                  r_aborted <= 1'b0;
                  r_success <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= (pktLen == '0) ? WAIT_ACK : STREAM;
               end
            end

            STREAM: begin
               if (abort) begin
                  r_txValid      <= 1'b0;
                  r_txLast       <= 1'b0;
                  r_aborted      <= 1'b1;
                  r_popTransDone <= 1'b1;
                  r_state        <= ROLLBACK;
               end else begin
                  if (w_pop) begin
                     r_txData  <= fifoData;
                     r_txValid <= 1'b1;
                     r_txLast  <= (r_popped == r_len - 1'b1);
                     r_popped  <= r_popped + 1'b1;
                  end else if (txReady) begin
                     r_txValid <= 1'b0;
                     r_txLast  <= 1'b0;
                  end
                  if (w_lastAccepted) begin
                     r_timeout <= '0;
                     r_state   <= WAIT_ACK;
                  end
               end
            end

            // NAK wins over a simultaneous ACK; silence for the full window counts as NAK.
            WAIT_ACK: begin
               if (abort) begin
                  r_aborted      <= 1'b1;
                  r_popTransDone <= 1'b1;
                  r_state        <= ROLLBACK;
               end else if (nakReceived) begin
                  r_popTransDone <= 1'b1;
                  r_state        <= ROLLBACK;
               end else if (ackReceived) begin
                  r_popTransDone    <= 1'b1;
                  r_popTransSuccess <= 1'b1;
                  r_state           <= COMMIT;
               end else if (w_timeoutHit) begin
                  r_popTransDone <= 1'b1;
                  r_state        <= ROLLBACK;
               end else begin
                  r_timeout <= r_timeout + 1'b1;
               end
            end

            COMMIT: begin
               r_done    <= 1'b1;
               r_success <= 1'b1;
               r_state   <= FINISH;
            end

            // The FIFO rewinds its read pointer on the rollback pulse, so a retry
            // simply restarts the byte count and re-reads the same data.
            ROLLBACK: begin
               if (r_aborted || w_retriesExhausted) begin
                  r_done    <= 1'b1;
                  r_success <= 1'b0;
                  r_state   <= FINISH;
               end else begin
                  r_retry   <= r_retry + 1'b1;
                  r_popped  <= '0;
                  r_timeout <= '0;
                  r_txValid <= 1'b0;
                  r_txData  <= '0;
                  r_txLast  <= 1'b0;
                  r_state   <= (r_len == '0) ? WAIT_ACK : STREAM;
               end
            end

            FINISH: begin
               r_busy    <= 1'b0;
               r_success <= 1'b0;
               r_state   <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Self-checking bench for fifo_packet_reader: a transactional FIFO model feeds the DUT,
// a packet-level reference model predicts the byte stream, handshake pulses and outcome.
module tb_fifo_packet_reader;

   localparam int TO = 16;
   localparam int MR = 3;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [9:0] pktLen;
   logic       busy;
   logic       dataAvailable;
   logic [7:0] fifoData;
   logic       popData;
   logic       popTransDone;
   logic       popTransSuccess;
   logic       txValid;
   logic [7:0] txData;
   logic       txLast;
   logic       txReady;
   logic       ackReceived;
   logic       nakReceived;
   logic       abort;
   logic       done;
   logic       success;
   logic [1:0] retryCount;

   fifo_packet_reader #(
      .DATA_WID(8),
      .LEN_WID(10),
      .TIMEOUT_CYCLES(TO),
      .MAX_RETRIES(MR)
   ) dut (
      .CLK(clk),
      .rst_n(rst_n),
      .start(start),
      .pktLen(pktLen),
      .busy(busy),
      .dataAvailable(dataAvailable),
      .fifoData(fifoData),
      .popData(popData),
      .popTransDone(popTransDone),
      .popTransSuccess(popTransSuccess),
      .txValid(txValid),
      .txData(txData),
      .txLast(txLast),
      .txReady(txReady),
      .ackReceived(ackReceived),
      .nakReceived(nakReceived),
      .abort(abort),
      .done(done),
      .success(success),
      .retryCount(retryCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transactional FIFO: a speculative read pointer that a commit keeps and a rollback rewinds.
   logic [7:0] fifoMem [256];
   int         wrPtr = 0;
   int         rdPtr = 0;
   int         cmPtr = 0;
   logic       underrun;
   logic       fifoFlush;

   assign dataAvailable = !underrun && (rdPtr != wrPtr);
   assign fifoData      = fifoMem[rdPtr[7:0]];

   always @(posedge clk) begin
      if (fifoFlush) begin
         rdPtr <= wrPtr;
         cmPtr <= wrPtr;
      end else begin
         if (popData) rdPtr <= rdPtr + 1;
         if (popTransDone) begin
            if (popTransSuccess) cmPtr <= rdPtr;
            else                 rdPtr <= cmPtr;
         end
      end
   end

   int tests = 0;
   int failures = 0;

   // Observation record, updated once per cycle at the falling edge.
   int         cyc = 0;
   logic [7:0] gotQ [$];
   bit         gotLastQ [$];
   int         hsCycQ [$];
   int         rbCycQ [$];
   int         pops = 0;
   int         commits = 0;
   int         rollbacks = 0;
   int         dones = 0;
   int         coincide = 0;
   int         attemptEnds = 0;
   int         firstValidCyc = -1;
   int         curLen = 0;
   bit         busyPrev = 1'b0;
   bit         doneSuccess;
   int         doneRetry;
   bit         doneBusy;

   typedef struct {
      string name;
      int    len;
      int    first;
      int    naks;
      int    delay;
      bit    noResp;
      int    readyMode;
      bit    randUnder;
      bit    stall;
      bit    expSuccess;
      int    expRetry;
      int    expTx;
   } vec_t;

   vec_t vecs [8];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic toPos();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleNeg();
      @(negedge clk);
      cyc++;
      if (popData) pops++;
      if (popData && popTransDone) coincide++;
      if (txValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (txValid && txReady) begin
         gotQ.push_back(txData);
         gotLastQ.push_back(txLast);
         hsCycQ.push_back(cyc);
         if (txLast) attemptEnds++;
      end
      if (popTransDone) begin
         if (popTransSuccess) commits++;
         else begin
            rollbacks++;
            rbCycQ.push_back(cyc);
            if (curLen == 0) attemptEnds++;
         end
      end
      if (curLen == 0 && busy && !busyPrev) attemptEnds++;
      busyPrev = busy;
      if (done) begin
         dones++;
         doneSuccess = success;
         doneRetry   = int'(retryCount);
         doneBusy    = busy;
      end
   endtask

   function automatic logic [31:0] outVec();
      return {14'b0, busy, txValid, txData, txLast, popData, popTransDone,
              popTransSuccess, done, success, retryCount};
   endfunction

   task automatic pushByte(input logic [7:0] b);
      fifoMem[wrPtr[7:0]] = b;
      wrPtr++;
   endtask

   task automatic flushFifo();
      toPos();
      fifoFlush = 1'b1;
      toPos();
      fifoFlush = 1'b0;
      sampleNeg();
   endtask

   // Packet-level outcome: every NAK or silent window costs one transmission until the
   // retry budget is spent.
   function automatic void predict(input int naks, input bit noResp,
                                   output bit s, output int r, output int t);
      if (noResp || naks > MR) begin
         s = 1'b0; r = MR; t = MR + 1;
      end else begin
         s = 1'b1; r = naks; t = naks + 1;
      end
   endfunction

   task automatic applyStimulus(input vec_t v);
      logic [7:0] pkt [$];
      logic [7:0] expBytes [$];
      bit         expLast [$];
      int gBase, pBase, cBase, rBase, dBase, coBase, hsBase, rbBase;
      int startCyc, seenEnds, respondAt, respCount, stallLeft, bad;
      bit stallDone;
      logic [7:0] b;

      for (int i = 0; i < v.len; i++) begin
         b = (v.first < 0) ? 8'($urandom) : 8'(v.first + i * 17);
         pkt.push_back(b);
         pushByte(b);
      end
      for (int t = 0; t < v.expTx; t++)
         for (int i = 0; i < v.len; i++) begin
            expBytes.push_back(pkt[i]);
            expLast.push_back(i == v.len - 1);
         end

      gBase = gotQ.size(); hsBase = hsCycQ.size(); rbBase = rbCycQ.size();
      pBase = pops; cBase = commits; rBase = rollbacks; dBase = dones; coBase = coincide;
      curLen = v.len; firstValidCyc = -1; seenEnds = attemptEnds;
      respondAt = -1; respCount = 0; stallLeft = 0; stallDone = 1'b0;

      toPos();
      start = 1'b1; pktLen = 10'(v.len); txReady = 1'b1; underrun = 1'b0;
      startCyc = cyc + 1;
      for (int i = 0; i < 3000; i++) begin
         sampleNeg();
         if (attemptEnds > seenEnds) begin
            seenEnds = attemptEnds;
            if (!v.noResp) respondAt = cyc + v.delay;
         end
         if (dones > dBase) break;
         toPos();
         start = 1'b0; ackReceived = 1'b0; nakReceived = 1'b0;
         if (respondAt == cyc + 1) begin
            if (respCount < v.naks) nakReceived = 1'b1;
            else                    ackReceived = 1'b1;
            respCount++;
            respondAt = -1;
         end
         case (v.readyMode)
            0:       txReady = 1'b1;
            1:       txReady = ((cyc + 1) % 2 == 0);
            default: txReady = ($urandom_range(0, 3) != 0);
         endcase
         if (v.stall && !stallDone && (gotQ.size() - gBase) >= 2) begin
            stallLeft = 3; stallDone = 1'b1;
         end
         if (stallLeft > 0) begin
            underrun = 1'b1; stallLeft--;
         end else begin
            underrun = v.randUnder ? ($urandom_range(0, 3) == 0) : 1'b0;
         end
      end
      checkOutput({v.name, "/doneCount"}, dones - dBase, 1);
      checkOutput({v.name, "/busyAtDone"}, doneBusy, 1);

      toPos();
      start = 1'b0; ackReceived = 1'b0; nakReceived = 1'b0; txReady = 1'b1; underrun = 1'b0;
      sampleNeg();
      checkOutput({v.name, "/busyAfter"}, busy, 0);

      checkOutput({v.name, "/success"}, doneSuccess, v.expSuccess);
      checkOutput({v.name, "/retryCount"}, doneRetry, v.expRetry);
      checkOutput({v.name, "/commits"}, commits - cBase, v.expSuccess ? 1 : 0);
      checkOutput({v.name, "/rollbacks"}, rollbacks - rBase, v.expSuccess ? v.expTx - 1 : v.expTx);
      checkOutput({v.name, "/pops"}, pops - pBase, v.len * v.expTx);
      checkOutput({v.name, "/popDuringDone"}, coincide - coBase, 0);
      checkOutput({v.name, "/streamLen"}, gotQ.size() - gBase, expBytes.size());
      bad = 0;
      if (gotQ.size() - gBase == expBytes.size())
         for (int i = 0; i < expBytes.size(); i++)
            if (gotQ[gBase + i] !== expBytes[i] || gotLastQ[gBase + i] !== expLast[i]) bad++;
      checkOutput({v.name, "/streamBadBytes"}, bad, 0);

      if (v.len == 0) checkOutput({v.name, "/noValid"}, firstValidCyc, -1);
      if (v.len > 0 && !v.randUnder)
         checkOutput({v.name, "/firstValidLatency"}, firstValidCyc - startCyc, 2);
      if (v.len > 0 && v.readyMode == 0 && !v.randUnder && !v.stall && hsCycQ.size() >= hsBase + v.len)
         checkOutput({v.name, "/backToBack"}, hsCycQ[hsBase + v.len - 1] - hsCycQ[hsBase], v.len - 1);
      if (v.noResp && v.len > 0) begin
         bad = 0;
         for (int t = 0; t < v.expTx; t++) begin
            int hi = hsBase + t * v.len + v.len - 1;
            int ri = rbBase + t;
            if (hi < hsCycQ.size() && ri < rbCycQ.size()) begin
               if (rbCycQ[ri] - hsCycQ[hi] != TO + 1) bad++;
            end else bad++;
         end
         checkOutput({v.name, "/waitWindow"}, bad, 0);
      end

      curLen = 0;
      flushFifo();
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t rv;
      int   pBase, rBase, cBase, dBase, aBase, abortPop;
      bit   reached;

      rst_n = 1'b0; start = 1'b0; pktLen = '0; txReady = 1'b1; ackReceived = 1'b0;
      nakReceived = 1'b0; abort = 1'b0; underrun = 1'b0; fifoFlush = 1'b0;

      vecs[0] = '{"basic",      3, 8'h11, 0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1};
      vecs[1] = '{"nakOnce",    3, 8'h11, 1, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 2};
      vecs[2] = '{"timeout",    3, 8'h11, 0, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3, 4};
      vecs[3] = '{"zeroLen",    0, 8'h11, 0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1};
      vecs[4] = '{"stall",      4, 8'h41, 0, 2, 1'b0, 1, 1'b0, 1'b1, 1'b1, 0, 1};
      vecs[5] = '{"nakExhaust", 2, 8'h10, 4, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3, 4};
      vecs[6] = '{"threeNaks",  5, 8'h05, 3, 3, 1'b0, 2, 1'b0, 1'b0, 1'b1, 3, 4};
      vecs[7] = '{"zeroLenTo",  0, 8'h00, 0, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3, 4};

      toPos();
      toPos();
      sampleNeg();
      checkOutput("resetOutputs", outVec(), 32'h0);
      toPos();
      rst_n = 1'b1;
      sampleNeg();

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Abort after two pops: no third pop, register empties at once, rollback without retry.
      for (int i = 0; i < 4; i++) pushByte(8'(8'hA1 + i));
      curLen = 4; firstValidCyc = -1;
      pBase = pops; rBase = rollbacks; cBase = commits; dBase = dones;
      toPos();
      start = 1'b1; pktLen = 10'd4;
      reached = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sampleNeg();
         if (pops - pBase >= 2) begin reached = 1'b1; break; end
         toPos();
         start = 1'b0;
      end
      checkOutput("abort/reachTwoPops", reached, 1);
      toPos();
      start = 1'b0; abort = 1'b1;
      sampleNeg();
      abortPop = popData;
      toPos();
      abort = 1'b0;
      sampleNeg();
      checkOutput("abort/popOnAbortEdge", abortPop, 0);
      checkOutput("abort/txValidAfter", txValid, 0);
      checkOutput("abort/rollbackPulse", {popTransDone, popTransSuccess}, 2'b10);
      for (int i = 0; i < 10 && dones == dBase; i++) begin
         toPos();
         sampleNeg();
      end
      checkOutput("abort/done", dones - dBase, 1);
      checkOutput("abort/success", doneSuccess, 0);
      checkOutput("abort/retryCount", doneRetry, 0);
      checkOutput("abort/rollbacks", rollbacks - rBase, 1);
      checkOutput("abort/commits", commits - cBase, 0);
      checkOutput("abort/pops", pops - pBase, 2);
      curLen = 0;
      flushFifo();

      // Reset in the middle of WAIT_ACK, then a fresh packet must be accepted.
      for (int i = 0; i < 3; i++) pushByte(8'(8'h5A + i));
      curLen = 3; aBase = attemptEnds; rBase = rollbacks; cBase = commits;
      toPos();
      start = 1'b1; pktLen = 10'd3;
      for (int i = 0; i < 50 && attemptEnds == aBase; i++) begin
         sampleNeg();
         toPos();
         start = 1'b0;
      end
      start = 1'b0;
      checkOutput("reset/reachWait", attemptEnds - aBase, 1);
      sampleNeg();
      toPos();
      sampleNeg();
      toPos();
      rst_n = 1'b0;
      sampleNeg();
      toPos();
      rst_n = 1'b1;
      sampleNeg();
      checkOutput("reset/outputsCleared", outVec(), 32'h0);
      checkOutput("reset/noTransPulse", (rollbacks - rBase) + (commits - cBase), 0);
      curLen = 0;
      flushFifo();
      applyStimulus('{"afterReset", 2, 8'h77, 0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1});

      for (int n = 0; n < 25; n++) begin
         bit s;
         int r, t;
         rv.name      = $sformatf("rand%0d", n);
         rv.len       = $urandom_range(0, 12);
         rv.first     = -1;
         rv.naks      = $urandom_range(0, 4);
         rv.delay     = $urandom_range(1, 6);
         rv.noResp    = ($urandom_range(0, 5) == 0);
         rv.readyMode = 2;
         rv.randUnder = 1'b1;
         rv.stall     = 1'b0;
         predict(rv.naks, rv.noResp, s, r, t);
         rv.expSuccess = s;
         rv.expRetry   = r;
         rv.expTx      = t;
         applyStimulus(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
